// File: rtl/calc_pkg.sv
// Shared definitions for the sequential calculator: funct encodings,
// FSM state and operation class.
package calc_pkg;

  // funct[2] selects operand A source (1 = op_a, 0 = prev_result);
  // funct[1:0] selects the operation class.
  localparam logic [2:0] FUNCT_ADD_TO_PREV   = 3'b000;
  localparam logic [2:0] FUNCT_SUB_TO_PREV   = 3'b001;
  localparam logic [2:0] FUNCT_MULT_WITH_PREV = 3'b010;
  localparam logic [2:0] FUNCT_DIV_BY_PREV   = 3'b011;
  localparam logic [2:0] FUNCT_ADD           = 3'b100;
  localparam logic [2:0] FUNCT_SUB           = 3'b101;
  localparam logic [2:0] FUNCT_MULT          = 3'b110;
  localparam logic [2:0] FUNCT_DIV           = 3'b111;

  localparam int unsigned FUNCT_PREV_BIT = 2;
  localparam logic [2:0]  FUNCT_OP_MASK  = 3'b011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ALU  = 2'd1,
    ITER = 2'd2,
    DONE = 2'd3
  } calc_state_t;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } calc_op_t;

  // Mult and div share the upper encoding bit and the iterative datapath.
  function automatic logic isMulDiv(input calc_op_t op);
    return op[1];
  endfunction

endpackage

// File: rtl/calc_iter_unit.sv
// Iterative W-cycle datapath: LSB-first shift-add multiplier and
// MSB-first restoring divider sharing one pair of shift registers.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   start        load operands and begin W iterations
//   divMode      0 = multiply, 1 = divide (sampled on start)
//   opA, opB     multiplicand/dividend, multiplier/divisor
//   done_c       high during the final iteration cycle
//   result_c     low product / quotient after the current iteration
//   highNz_c     high half of product nonzero after the current iteration
module calc_iter_unit #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         divMode,
  input  logic [W-1:0] opA,
  input  logic [W-1:0] opB,
  output logic         done_c,
  output logic [W-1:0] result_c,
  output logic         highNz_c
);

  localparam int unsigned CNT_W = $clog2(W);

  logic [W-1:0]     hiQ, loQ, opBQ;
  logic [W-1:0]     hiStep, loStep;
  logic [CNT_W-1:0] cntQ;
  logic             modeQ, runQ;

  logic [W-1:0] addend;
  logic [W:0]   mulSum;
  logic [W:0]   divShift;
  logic [W-1:0] divDiff;
  logic         divGe;

  // One iteration step; the shifted remainder is always < 2*divisor, so the
  // restored difference fits in W bits.
  always_comb begin
    addend   = loQ[0] ? opBQ : '0;
    mulSum   = {1'b0, hiQ} + {1'b0, addend};
    divShift = {hiQ, loQ[W-1]};
    divGe    = (divShift >= {1'b0, opBQ});
    divDiff  = divShift[W-1:0] - opBQ;
    if (modeQ) begin
      hiStep = divGe ? divDiff : divShift[W-1:0];
      loStep = {loQ[W-2:0], divGe};
    end else begin
      hiStep = mulSum[W:1];
      loStep = {mulSum[0], loQ[W-1:1]};
    end
  end

  // Operand/shift registers and iteration counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hiQ   <= '0;
      loQ   <= '0;
      opBQ  <= '0;
      modeQ <= 1'b0;
      runQ  <= 1'b0;
      cntQ  <= '0;
    end else if (start) begin
      hiQ   <= '0;
      loQ   <= opA;
      opBQ  <= opB;
      modeQ <= divMode;
      runQ  <= 1'b1;
      cntQ  <= CNT_W'(W - 1);
    end else if (runQ) begin
      hiQ  <= hiStep;
      loQ  <= loStep;
      cntQ <= cntQ - CNT_W'(1);
      if (cntQ == '0) runQ <= 1'b0;
    end
  end

  assign done_c   = runQ && (cntQ == '0);
  assign result_c = loStep;
  assign highNz_c = |hiStep;

endmodule

// File: rtl/calc_seq_unit.sv
// Multi-cycle calculator: accepts an opcode and operands over valid/ready,
// runs add/sub in one ALU cycle or mult/div over W iterations, and returns
// result and flags over a second valid/ready handshake. Owns prev_result.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   in_valid, in_ready    request handshake (in_ready = state is IDLE)
//   funct, op_a, op_b     opcode and operands
//   out_valid, out_ready  result handshake
//   result, carry         result value, carry/borrow/high-half flag
//   div_by_zero, illegal  error flags
//   prev_result           stored previous result
//   busy                  state is not IDLE
module calc_seq_unit
  import calc_pkg::*;
#(
  parameter int unsigned W         = 8,
  parameter bit          MULDIV_EN = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [2:0]   funct,
  input  logic [W-1:0] op_a,
  input  logic [W-1:0] op_b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic         carry,
  output logic         div_by_zero,
  output logic         illegal,
  output logic [W-1:0] prev_result,
  output logic         busy
);

  calc_state_t  stateQ, stateD;
  calc_op_t     opQ, opD, reqOp;
  logic [W-1:0] aQ, aD, bQ, bD, aSel;
  logic [W-1:0] resultQ, resultD, prevQ, prevD;
  logic         carryQ, carryD, dzQ, dzD, illQ, illD, ovQ, ovD;
  logic [W:0]   addSum;
  logic [W-1:0] subDiff;
  logic         iterStart;
  logic         iterDone_c, iterHighNz_c;
  logic [W-1:0] iterResult_c;

  // Next-state and output-register logic.
  always_comb begin
    stateD    = stateQ;
    opD       = opQ;
    aD        = aQ;
    bD        = bQ;
    resultD   = resultQ;
    prevD     = prevQ;
    carryD    = carryQ;
    dzD       = dzQ;
    illD      = illQ;
    ovD       = ovQ;
    iterStart = 1'b0;
    aSel      = funct[FUNCT_PREV_BIT] ? op_a : prevQ;
    reqOp     = calc_op_t'(funct[1:0]);
    addSum    = {1'b0, aQ} + {1'b0, bQ};
    subDiff   = aQ - bQ;

    case (stateQ)
      IDLE: begin
        if (in_valid) begin
          aD  = aSel;
          bD  = op_b;
          opD = reqOp;
          if (!isMulDiv(reqOp)) begin
            stateD = ALU;
          end else if (!MULDIV_EN) begin
            stateD  = DONE;
            resultD = '0;
            illD    = 1'b1;
          end else if ((reqOp == OP_DIV) && (op_b == '0)) begin
            stateD  = DONE;
            resultD = '1;
            dzD     = 1'b1;
          end else begin
            stateD    = ITER;
            iterStart = 1'b1;
          end
        end
      end
      ALU: begin
        if (opQ == OP_SUB) begin
          resultD = subDiff;
          carryD  = (aQ < bQ);
        end else begin
          resultD = addSum[W-1:0];
          carryD  = addSum[W];
        end
        stateD = DONE;
      end
      ITER: begin
        if (iterDone_c) begin
          resultD = iterResult_c;
          carryD  = (opQ == OP_MUL) && iterHighNz_c;
          stateD  = DONE;
        end
      end
      DONE: begin
        // out_valid rises one cycle after entering DONE, then holds until taken.
        if (!ovQ) begin
          ovD = 1'b1;
        end else if (out_ready) begin
          ovD    = 1'b0;
          stateD = IDLE;
          if (!(dzQ || illQ)) prevD = resultQ;
          carryD = 1'b0;
          dzD    = 1'b0;
          illD   = 1'b0;
        end
      end
      default: stateD = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateQ  <= IDLE;
      opQ     <= OP_ADD;
      aQ      <= '0;
      bQ      <= '0;
      resultQ <= '0;
      prevQ   <= '0;
      carryQ  <= 1'b0;
      dzQ     <= 1'b0;
      illQ    <= 1'b0;
      ovQ     <= 1'b0;
    end else begin
      stateQ  <= stateD;
      opQ     <= opD;
      aQ      <= aD;
      bQ      <= bD;
      resultQ <= resultD;
      prevQ   <= prevD;
      carryQ  <= carryD;
      dzQ     <= dzD;
      illQ    <= illD;
      ovQ     <= ovD;
    end
  end

  generate
    if (MULDIV_EN) begin : gIter
      calc_iter_unit #(.W(W)) uIter (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (iterStart),
        .divMode  (reqOp == OP_DIV),
        .opA      (aSel),
        .opB      (op_b),
        .done_c   (iterDone_c),
        .result_c (iterResult_c),
        .highNz_c (iterHighNz_c)
      );
    end else begin : gNoIter
      assign iterDone_c   = 1'b0;
      assign iterResult_c = '0;
      assign iterHighNz_c = 1'b0;
    end
  endgenerate

  assign in_ready    = (stateQ == IDLE);
  assign busy        = (stateQ != IDLE);
  assign out_valid   = ovQ;
  assign result      = resultQ;
  assign carry       = carryQ;
  assign div_by_zero = dzQ;
  assign illegal     = illQ;
  assign prev_result = prevQ;

endmodule

// File: tb/tb_calc_seq_unit.sv
// Directed bench for calc_seq_unit: main instance W=8 with mult/div, plus a
// second instance with mult/div disabled.
module tb_calc_seq_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       inValid, inReady, outValid, outReady;
  logic [2:0] funct;
  logic [7:0] opA, opB, result, prevResult;
  logic       carry, divByZero, illegal, busy;

  logic       inValid0, inReady0, outValid0, outReady0;
  logic [2:0] funct0;
  logic [7:0] opA0, opB0, result0, prevResult0;
  logic       carry0, divByZero0, illegal0, busy0;

  int nChecks = 0;
  int nFail   = 0;

  always #5 clk = ~clk;

  calc_seq_unit #(.W(8), .MULDIV_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(inValid), .in_ready(inReady),
    .funct(funct), .op_a(opA), .op_b(opB), .out_valid(outValid),
    .out_ready(outReady), .result(result), .carry(carry),
    .div_by_zero(divByZero), .illegal(illegal), .prev_result(prevResult),
    .busy(busy)
  );

  calc_seq_unit #(.W(8), .MULDIV_EN(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(inValid0), .in_ready(inReady0),
    .funct(funct0), .op_a(opA0), .op_b(opB0), .out_valid(outValid0),
    .out_ready(outReady0), .result(result0), .carry(carry0),
    .div_by_zero(divByZero0), .illegal(illegal0), .prev_result(prevResult0),
    .busy(busy0)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Issue one request with out_ready high; check latency, result, flags and
  // prev_result after the output handshake. Entered at posedge+1 with DUT idle.
  task automatic runOp(input string tag, input logic [2:0] f, input logic [7:0] a,
                       input logic [7:0] b, input logic [7:0] expRes,
                       input logic expCarry, input logic expDz, input int expLat,
                       input logic [7:0] expPrev);
    int lat;
    check({tag, " in_ready"}, 32'(inReady), 32'd1);
    inValid = 1'b1; funct = f; opA = a; opB = b;
    @(posedge clk); #1;
    inValid = 1'b0;
    lat = 0;
    while (!outValid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'(expLat));
    check({tag, " result"}, 32'(result), 32'(expRes));
    check({tag, " carry"}, 32'(carry), 32'(expCarry));
    check({tag, " div_by_zero"}, 32'(divByZero), 32'(expDz));
    check({tag, " illegal"}, 32'(illegal), 32'd0);
    @(posedge clk); #1;
    check({tag, " out_valid fall"}, 32'(outValid), 32'd0);
    check({tag, " prev_result"}, 32'(prevResult), 32'(expPrev));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; inValid = 1'b0; outReady = 1'b1; funct = 3'b000; opA = 8'd0; opB = 8'd0;
    inValid0 = 1'b0; outReady0 = 1'b1; funct0 = 3'b000; opA0 = 8'd0; opB0 = 8'd0;
    #12;
    check("reset in_ready", 32'(inReady), 32'd1);
    check("reset out_valid", 32'(outValid), 32'd0);
    check("reset result", 32'(result), 32'd0);
    check("reset prev_result", 32'(prevResult), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    runOp("ADD 100+27", 3'b100, 8'd100, 8'd27, 8'd127, 1'b0, 1'b0, 2, 8'd127);
    runOp("SUBToPrev 127-200", 3'b001, 8'd55, 8'd200, 8'd183, 1'b1, 1'b0, 2, 8'd183);
    runOp("MULT 15*17", 3'b110, 8'd15, 8'd17, 8'd255, 1'b0, 1'b0, 9, 8'd255);
    runOp("MULT 16*16", 3'b110, 8'd16, 8'd16, 8'd0, 1'b1, 1'b0, 9, 8'd0);
    runOp("ADD 1+2", 3'b100, 8'd1, 8'd2, 8'd3, 1'b0, 1'b0, 2, 8'd3);
    runOp("MULTWithPrev 3*5", 3'b010, 8'd99, 8'd5, 8'd15, 1'b0, 1'b0, 9, 8'd15);
    runOp("DIV 200/7", 3'b111, 8'd200, 8'd7, 8'd28, 1'b0, 1'b0, 9, 8'd28);
    runOp("DIV 9/0", 3'b111, 8'd9, 8'd0, 8'hFF, 1'b0, 1'b1, 1, 8'd28);

    // Mult/div disabled instance.
    inValid0 = 1'b1; funct0 = 3'b111; opA0 = 8'd9; opB0 = 8'd3;
    @(posedge clk); #1;
    inValid0 = 1'b0;
    check("noMD out_valid", 32'(outValid0), 32'd0);
    @(posedge clk); #1;
    check("noMD out_valid lat1", 32'(outValid0), 32'd1);
    check("noMD result", 32'(result0), 32'd0);
    check("noMD illegal", 32'(illegal0), 32'd1);
    check("noMD div_by_zero", 32'(divByZero0), 32'd0);
    @(posedge clk); #1;
    check("noMD out_valid fall", 32'(outValid0), 32'd0);
    check("noMD illegal clear", 32'(illegal0), 32'd0);
    check("noMD prev_result", 32'(prevResult0), 32'd0);

    // Backpressure: hold out_ready low, ignored second request.
    outReady = 1'b0;
    inValid = 1'b1; funct = 3'b100; opA = 8'd1; opB = 8'd1;
    @(posedge clk); #1;
    inValid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      check("bp out_valid", 32'(outValid), 32'd1);
      check("bp result", 32'(result), 32'd2);
      check("bp carry", 32'(carry), 32'd0);
      check("bp in_ready", 32'(inReady), 32'd0);
      inValid = (i == 1); funct = 3'b101; opA = 8'd9; opB = 8'd4;
      @(posedge clk); #1;
      inValid = 1'b0;
    end
    outReady = 1'b1;
    @(posedge clk); #1;
    check("bp out_valid fall", 32'(outValid), 32'd0);
    check("bp prev_result", 32'(prevResult), 32'd2);
    check("bp busy after", 32'(busy), 32'd0);
    runOp("SUB 9-4", 3'b101, 8'd9, 8'd4, 8'd5, 1'b0, 1'b0, 2, 8'd5);

    // Reset during the 4th ITER cycle of MULT 13*11.
    inValid = 1'b1; funct = 3'b110; opA = 8'd13; opB = 8'd11;
    @(posedge clk); #1;
    inValid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    check("midIter busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async rst out_valid", 32'(outValid), 32'd0);
    check("async rst result", 32'(result), 32'd0);
    check("async rst prev_result", 32'(prevResult), 32'd0);
    check("async rst in_ready", 32'(inReady), 32'd1);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("post rst in_ready", 32'(inReady), 32'd1);
    runOp("ADD 1+2 post rst", 3'b100, 8'd1, 8'd2, 8'd3, 1'b0, 1'b0, 2, 8'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
